sar_search: RTL and testbench

SAR_SEARCH -- requirements
Module: sar_search

---
 rtl/sar_search.sv | 139 +++++++++++++
 tb/tb_sar_search.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// MSB-first successive-approximation search engine driving an external
// magnitude comparator through a probe / response handshake.
module sar_search #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_valid,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic [WIDTH-1:0] probe,
  output logic             probe_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, UPDATE, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  probe_q, probe_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              found_q, found_d;
  logic              eq_q, eq_d;
  logic              gt_q, gt_d;
  logic              pv_q, pv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  acc_upd;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    probe_d  = probe_q;
    result_d = result_q;
    found_d  = found_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    acc_upd  = acc_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          acc_d   = '0;
          idx_d   = IDX_W'(WIDTH - 1);
          probe_d = ONE << (WIDTH - 1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cmp_valid) begin
          eq_d    = cmp_eq;
          gt_d    = cmp_gt;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (eq_q) begin
          // EQ wins even when gt was captured alongside it
          result_d = probe_q;
          found_d  = 1'b1;
          state_d  = DONE;
        end else begin
          acc_upd = gt_q ? (acc_q | (ONE << idx_q)) : (acc_q & ~(ONE << idx_q));
          acc_d   = acc_upd;
          if (idx_q == '0) begin
            result_d = acc_upd;
            found_d  = 1'b0;
            state_d  = DONE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            probe_d = acc_upd | (ONE << (idx_q - IDX_W'(1)));
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are decoded from the next state so they register in step with it
    pv_d   = (state_d == ISSUE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      probe_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      pv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      found_q  <= found_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      pv_q     <= pv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign probe       = probe_q;
  assign probe_valid = pv_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign found       = found_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: a behavioural comparator answers each probe
// against a chosen target, with configurable wait cycles.
module tb_sar_search;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start, abort, cmp_valid, cmp_eq, cmp_gt;
  logic [7:0] probe, result;
  logic       probe_valid, busy, done, found;

  int tests_run = 0;
  int tests_failed = 0;

  int         n_probes, done_cyc, done_cnt, busy_low_cyc;
  bit         stable_ok;
  logic [7:0] probe_log [16];

  sar_search #(.WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .cmp_valid(cmp_valid), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .probe(probe), .probe_valid(probe_valid), .busy(busy), .done(done),
    .result(result), .found(found)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Starts a search and plays the comparator until busy drops.
  task automatic run_search(input logic [7:0] target, input int waits, input int abort_at,
                            input bit start_mid, input bit gt_with_eq);
    int         cyc, wcnt;
    logic [7:0] cur;
    bit         prev_pv, fin;
    cyc = 0; wcnt = 0; cur = 8'h00; prev_pv = 1'b0; fin = 1'b0;
    n_probes = 0; done_cyc = 0; done_cnt = 0; busy_low_cyc = 0; stable_ok = 1'b1;
    @(negedge clock);
    start = 1'b1;
    while (!fin) begin
      @(negedge clock);
      cyc++;
      start = start_mid && (cyc == 5);
      abort = 1'b0;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!busy) begin
        busy_low_cyc = cyc;
        fin = 1'b1;
      end else if (cyc > 300) begin
        check("timeout", 32'(cyc), 32'd0);
        fin = 1'b1;
      end else begin
        if (probe_valid && !prev_pv) begin
          if (n_probes < 16) probe_log[n_probes] = probe;
          n_probes++;
          cur  = probe;
          wcnt = 0;
          if (n_probes == abort_at) abort = 1'b1;
        end else if (probe_valid && probe !== cur) begin
          stable_ok = 1'b0;
        end
        prev_pv = probe_valid;
        if (probe_valid && wcnt >= waits) begin
          cmp_valid = 1'b1;
          cmp_eq    = (probe == target);
          cmp_gt    = (target > probe) || (gt_with_eq && probe == target);
        end else begin
          // Garbage on eq/gt while unqualified must be ignored
          cmp_valid = 1'b0;
          cmp_eq    = 1'b1;
          cmp_gt    = 1'b1;
        end
        if (probe_valid) wcnt++;
      end
    end
    start = 1'b0; abort = 1'b0; cmp_valid = 1'b0; cmp_eq = 1'b0; cmp_gt = 1'b0;
  endtask

  task automatic check_probes(input string tag, input logic [7:0] exp [8], input int n);
    check({tag, " nprobes"}, 32'(n_probes), 32'(n));
    for (int i = 0; i < n && i < n_probes; i++)
      check($sformatf("%s probe%0d", tag, i), 32'(probe_log[i]), 32'(exp[i]));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " probe"}, 32'(probe), 32'd0);
    check({tag, " result"}, 32'(result), 32'd0);
    check({tag, " probe_valid"}, 32'(probe_valid), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " found"}, 32'(found), 32'd0);
  endtask

  logic [7:0] exp_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
  logic [7:0] exp_00 [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic [7:0] exp_3c [8] = '{8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h3C, 8'h00, 8'h00};
  logic [7:0] exp_ff [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

  initial begin
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; cmp_valid = 1'b0; cmp_eq = 1'b0; cmp_gt = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_idle_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;

    run_search(8'hA5, 0, 0, 1'b0, 1'b0);
    check_probes("A5", exp_a5, 8);
    check("A5 result", 32'(result), 32'hA5);
    check("A5 found", 32'(found), 32'd1);
    check("A5 done_cyc", 32'(done_cyc), 32'd17);
    check("A5 done_cnt", 32'(done_cnt), 32'd1);

    run_search(8'h00, 0, 0, 1'b0, 1'b0);
    check_probes("00", exp_00, 8);
    check("00 result", 32'(result), 32'h00);
    check("00 found", 32'(found), 32'd0);
    check("00 done_cyc", 32'(done_cyc), 32'd17);

    run_search(8'h80, 0, 0, 1'b0, 1'b0);
    check("80 result", 32'(result), 32'h80);
    check("80 found", 32'(found), 32'd1);
    check("80 done_cyc", 32'(done_cyc), 32'd3);
    check("80 busy_low_cyc", 32'(busy_low_cyc), 32'd4);

    run_search(8'h3C, 3, 0, 1'b0, 1'b0);
    check_probes("3C", exp_3c, 6);
    check("3C stable", 32'(stable_ok), 32'd1);
    check("3C result", 32'(result), 32'h3C);
    check("3C found", 32'(found), 32'd1);
    check("3C done_cyc", 32'(done_cyc), 32'd31);

    run_search(8'h11, 0, 4, 1'b0, 1'b0);
    check("abort busy_low_cyc", 32'(busy_low_cyc), 32'd8);
    check("abort probe_valid", 32'(probe_valid), 32'd0);
    check("abort done_cnt", 32'(done_cnt), 32'd0);
    check("abort result kept", 32'(result), 32'h3C);
    check("abort found kept", 32'(found), 32'd1);

    run_search(8'hFF, 0, 0, 1'b0, 1'b0);
    check_probes("FF", exp_ff, 8);
    check("FF result", 32'(result), 32'hFF);
    check("FF found", 32'(found), 32'd1);

    @(negedge clock);
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    check("idle abort+start busy", 32'(busy), 32'd0);
    start = 1'b0; abort = 1'b0;
    @(negedge clock);
    check("idle abort+start busy2", 32'(busy), 32'd0);

    run_search(8'h40, 0, 0, 1'b0, 1'b1);
    check("eq_gt result", 32'(result), 32'h40);
    check("eq_gt found", 32'(found), 32'd1);
    check("eq_gt done_cyc", 32'(done_cyc), 32'd5);

    run_search(8'hA5, 0, 0, 1'b1, 1'b0);
    check_probes("mid_start", exp_a5, 8);
    check("mid_start done_cnt", 32'(done_cnt), 32'd1);
    check("mid_start done_cyc", 32'(done_cyc), 32'd17);

    // Asynchronous reset in the middle of a search
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cmp_valid = 1'b1; cmp_eq = 1'b0; cmp_gt = 1'b1;
    repeat (3) @(negedge clock);
    check("pre-reset busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_zero("async reset");
    cmp_valid = 1'b0; cmp_gt = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    run_search(8'hA5, 0, 0, 1'b0, 1'b0);
    check_probes("post-reset", exp_a5, 8);
    check("post-reset result", 32'(result), 32'hA5);
    check("post-reset done_cyc", 32'(done_cyc), 32'd17);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
